// File: rtl/jtframe_objdraw.sv
// Object line drawer: fetches four 16-bit ROM words (16 pixels at 4bpp) for
// one sprite row and writes the non-transparent ones into a line buffer.
//
// ROM handshake: rom_cs is held high with rom_addr stable until a rom_ok is
// accepted. The first cycle of each fetch is a settle cycle in which rom_ok
// is ignored. This covers a registered address mux upstream and an ok that
// still belongs to the previous address. The word is accepted on the first
// later cycle with rom_ok=1.
module jtframe_objdraw #(
    parameter int AW   = 13,
    parameter int PALW = 4,
    localparam int CW  = AW - 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CW-1:0]   code,
    input  logic [3:0]      vrow,
    input  logic [8:0]      xpos,
    input  logic            hflip,
    input  logic [PALW-1:0] pal,
    output logic            busy,
    output logic [AW-1:0]   rom_addr,
    output logic            rom_cs,
    input  logic [15:0]     rom_data,
    input  logic            rom_ok,
    output logic            buf_we,
    output logic [8:0]      buf_addr,
    output logic [PALW+3:0] buf_data,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAW} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_code;
    logic [3:0]      r_vrow;
    logic            r_hflip;
    logic [PALW-1:0] r_pal;
    logic [8:0]      r_px;
    logic [1:0]      r_w;
    logic [1:0]      r_wcnt;
    logic [1:0]      r_cnt;
    logic            r_settle;
    logic [15:0]     r_shift;

    logic [15:0]     w_src;
    logic [3:0]      w_nib;
    logic [15:0]     w_next_shift;
    logic [1:0]      w_next_w;

    assign dbg_state = r_state;

    // The first pixel of a word comes straight from rom_data on the capture
    // cycle. Later pixels come from the shift register.
    always_comb begin
        w_src        = (r_state == S_FETCH) ? rom_data : r_shift;
        w_nib        = r_hflip ? w_src[3:0] : w_src[15:12];
        w_next_shift = r_hflip ? {4'd0, w_src[15:4]} : {w_src[11:0], 4'd0};
        w_next_w     = r_hflip ? (r_w - 2'd1) : (r_w + 2'd1);
    end

    // Main FSM. All outputs are registered. buf_we pulses only for pixels
    // that are emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_code   <= '0;
            r_vrow   <= '0;
            r_hflip  <= 1'b0;
            r_pal    <= '0;
            r_px     <= '0;
            r_w      <= '0;
            r_wcnt   <= '0;
            r_cnt    <= '0;
            r_settle <= 1'b0;
            r_shift  <= '0;
            busy     <= 1'b0;
            rom_addr <= '0;
            rom_cs   <= 1'b0;
            buf_we   <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else begin
            buf_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_code   <= code;
                        r_vrow   <= vrow;
                        r_hflip  <= hflip;
                        r_pal    <= pal;
                        r_px     <= xpos;
                        r_w      <= hflip ? 2'd3 : 2'd0;
                        r_wcnt   <= 2'd0;
                        r_settle <= 1'b1;
                        rom_addr <= {code, vrow, (hflip ? 2'd3 : 2'd0)};
                        rom_cs   <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (r_settle) begin
                        r_settle <= 1'b0;
                    end else if (rom_ok) begin
                        rom_cs   <= 1'b0;
                        r_shift  <= w_next_shift;
                        buf_addr <= r_px;
                        buf_data <= {r_pal, w_nib};
                        buf_we   <= (w_nib != 4'd0);
                        r_px     <= r_px + 9'd1;
                        r_cnt    <= 2'd0;
                        r_state  <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (r_cnt == 2'd3) begin
                        if (r_wcnt == 2'd3) begin
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_w      <= w_next_w;
                            r_wcnt   <= r_wcnt + 2'd1;
                            rom_addr <= {r_code, r_vrow, w_next_w};
                            rom_cs   <= 1'b1;
                            r_settle <= 1'b1;
                            r_state  <= S_FETCH;
                        end
                    end else begin
                        r_shift  <= w_next_shift;
                        buf_addr <= r_px;
                        buf_data <= {r_pal, w_nib};
                        buf_we   <= (w_nib != 4'd0);
                        r_px     <= r_px + 9'd1;
                        r_cnt    <= r_cnt + 2'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_objdraw.sv
// Bench for jtframe_objdraw: ROM model with configurable ok latency,
// line-buffer write capture, and a row-level reference model.
module tb_jtframe_objdraw;
  localparam int AW   = 13;
  localparam int PALW = 4;
  localparam int CW   = AW - 6;
  localparam int W    = 9 + PALW + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic [CW-1:0]   code  = '0;
  logic [3:0]      vrow  = '0;
  logic [8:0]      xpos  = '0;
  logic            hflip = 1'b0;
  logic [PALW-1:0] pal   = '0;
  logic            busy;
  logic [AW-1:0]   rom_addr;
  logic            rom_cs;
  logic [15:0]     rom_data;
  logic            rom_ok;
  logic            buf_we;
  logic [8:0]      buf_addr;
  logic [PALW+3:0] buf_data;
  logic [1:0]      dbg_state;

  jtframe_objdraw #(.AW(AW), .PALW(PALW)) dut (
    .clk(clk), .rst(rst), .start(start), .code(code), .vrow(vrow),
    .xpos(xpos), .hflip(hflip), .pal(pal), .busy(busy),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data),
    .rom_ok(rom_ok), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_data(buf_data), .dbg_state(dbg_state)
  );

  // ---------------- ROM model ----------------
  // Data lags the address by one cycle. ok is either tied high (stale mode)
  // or raised on the ok_at-th cycle of a fetch.
  logic [15:0] mem [0:(1<<AW)-1];
  int ok_at = 2;
  bit stale = 1'b0;
  int cs_run = 0;

  always @(posedge clk) rom_data <= mem[rom_addr];
  always @(posedge clk) cs_run <= rom_cs ? cs_run + 1 : 0;
  assign rom_ok = stale ? 1'b1 : (rom_cs && (cs_run + 1 >= ok_at));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  obs_q[$];
  logic [AW-1:0] addr_exp[$];
  logic [AW-1:0] addr_obs[$];
  bit   mon_en = 1'b0;
  int   busy_cnt, cs_cnt, we_cs_bad;
  logic prev_cs;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) busy_cnt++;
      if (rom_cs) cs_cnt++;
      if (buf_we && rom_cs) we_cs_bad++;
      if (buf_we) obs_q.push_back({buf_addr, buf_data});
      if (rom_cs && !prev_cs) addr_obs.push_back(rom_addr);
      prev_cs = rom_cs;
    end
  end

  // Reference: row pixels in screen order, word by word, nibble by nibble.
  task automatic model(input logic [CW-1:0] c, input logic [3:0] v,
                       input logic [8:0] x, input logic h, input logic [PALW-1:0] p);
    exp_q.delete();
    addr_exp.delete();
    for (int k = 0; k < 4; k++) begin
      int wi;
      logic [AW-1:0] a;
      logic [15:0] d;
      wi = h ? 3 - k : k;
      a  = {c, v, wi[1:0]};
      addr_exp.push_back(a);
      d = mem[a];
      for (int j = 0; j < 4; j++) begin
        int sh;
        logic [3:0] n;
        logic [8:0] pa;
        sh = h ? 4 * j : 12 - 4 * j;
        n  = 4'((d >> sh) & 16'hF);
        pa = 9'((int'(x) + 4 * k + j) % 512);
        if (n != 4'd0) exp_q.push_back({pa, p, n});
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run(input logic [CW-1:0] c, input logic [3:0] v, input logic [8:0] x,
                     input logic h, input logic [PALW-1:0] p, input int oka, input bit st,
                     input bit second, input int exp_busy, input int exp_nwr);
    bit timed_out;
    int fc, mism;
    ok_at = oka;
    stale = st;
    fc = st ? 2 : (oka < 2 ? 2 : oka);
    @(negedge clk);
    obs_q.delete(); addr_obs.delete();
    busy_cnt = 0; cs_cnt = 0; we_cs_bad = 0; prev_cs = 1'b0;
    model(c, v, x, h, p);
    code = c; vrow = v; xpos = x; hflip = h; pal = p;
    start = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    code = CW'($urandom); vrow = 4'($urandom); xpos = 9'($urandom);
    hflip = 1'($urandom); pal = PALW'($urandom);
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      start = second && (i == 10);
      @(negedge clk);
    end
    start = 1'b0;
    mon_en = 1'b0;
    chk("timeout", int'(timed_out), 0);
    chk("busy_cycles", busy_cnt, exp_busy);
    chk("rom_cs_cycles", cs_cnt, 4 * fc);
    chk("we_during_fetch", we_cs_bad, 0);
    chk("fetch_count", addr_obs.size(), 4);
    mism = 0;
    for (int i = 0; i < 4 && i < addr_obs.size(); i++)
      if (addr_obs[i] != addr_exp[i]) mism++;
    chk("fetch_order", mism, 0);
    chk("write_count", obs_q.size(), exp_q.size());
    if (exp_nwr >= 0) chk("write_count_plan", obs_q.size(), exp_nwr);
    mism = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] != exp_q[i]) begin
        if (mism == 0) $display("  first write diff at %0d: got %h want %h", i, obs_q[i], exp_q[i]);
        mism++;
      end
    chk("write_data", mism, 0);
    repeat (3) @(negedge clk);
    chk("idle_after", int'(busy), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_rom_cs"}, int'(rom_cs), 0);
    chk({tag, "_rom_addr"}, int'(rom_addr), 0);
    chk({tag, "_buf_we"}, int'(buf_we), 0);
    chk({tag, "_buf_addr"}, int'(buf_addr), 0);
    chk({tag, "_buf_data"}, int'(buf_data), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [CW-1:0]   code;
    logic [3:0]      vrow;
    logic [8:0]      xpos;
    logic            hflip;
    logic [PALW-1:0] pal;
    int              ok_at;
    bit              stale;
    bit              second;
    int              exp_busy;
    int              exp_nwr;
  } vec_t;

  function automatic vec_t mkvec(input int c, input int v, input int x, input int h,
                                 input int p, input int oka, input int st, input int sec,
                                 input int eb, input int en);
    vec_t r;
    r.code = CW'(c); r.vrow = 4'(v); r.xpos = 9'(x); r.hflip = 1'(h); r.pal = PALW'(p);
    r.ok_at = oka; r.stale = 1'(st); r.second = 1'(sec); r.exp_busy = eb; r.exp_nwr = en;
    return r;
  endfunction

  vec_t vt[5];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
    mem[13'h14C] = 16'h1234; mem[13'h14D] = 16'h5678;
    mem[13'h14E] = 16'h9ABC; mem[13'h14F] = 16'hDEF0;
    mem[13'h1C0] = 16'h1111; mem[13'h1C1] = 16'h2345;
    mem[13'h1C2] = 16'h6789; mem[13'h1C3] = 16'hABCD;

    vt[0] = mkvec(5, 3, 100, 0, 2, 2, 0, 0, 24, 15);  // basic
    vt[1] = mkvec(5, 3, 100, 1, 2, 2, 0, 0, 24, 15);  // flipped
    vt[2] = mkvec(7, 0, 505, 0, 9, 2, 0, 0, 24, 16);  // x wrap
    vt[3] = mkvec(5, 3, 100, 0, 2, 2, 1, 0, 24, 15);  // ok tied high
    vt[4] = mkvec(5, 3, 100, 0, 2, 6, 0, 1, 40, 15);  // 5-cycle ok, extra start

    // reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;

    for (int t = 0; t < 5; t++) begin
      run(vt[t].code, vt[t].vrow, vt[t].xpos, vt[t].hflip, vt[t].pal,
          vt[t].ok_at, vt[t].stale, vt[t].second, vt[t].exp_busy, vt[t].exp_nwr);
      if (t == 0) begin
        chk("first_fetch_addr", (addr_obs.size() > 0) ? int'(addr_obs[0]) : -1, 'h14C);
        chk("first_write", (obs_q.size() > 0) ? int'(obs_q[0]) : -1, int'({9'd100, 4'd2, 4'd1}));
        chk("last_write", (obs_q.size() > 14) ? int'(obs_q[14]) : -1, int'({9'd114, 4'd2, 4'd15}));
      end
      if (t == 1) begin
        chk("flip_first_fetch", (addr_obs.size() > 0) ? int'(addr_obs[0]) : -1, 'h14F);
        chk("flip_first_write", (obs_q.size() > 0) ? int'(obs_q[0]) : -1, int'({9'd101, 4'd2, 4'd15}));
        chk("flip_last_write", (obs_q.size() > 14) ? int'(obs_q[14]) : -1, int'({9'd115, 4'd2, 4'd1}));
      end
    end

    // reset pulsed mid-draw, then a clean request
    begin
      bit seen_we;
      ok_at = 2; stale = 1'b0;
      @(negedge clk);
      code = CW'(5); vrow = 4'd3; xpos = 9'd100; hflip = 1'b0; pal = PALW'(2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen_we = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (buf_we) begin
          seen_we = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("reached_draw", int'(seen_we), 1);
      #2 rst = 1'b1;
      #1 chk_zero_outputs("async_rst");
      @(negedge clk);
      rst = 1'b0;
      run(vt[0].code, vt[0].vrow, vt[0].xpos, vt[0].hflip, vt[0].pal,
          2, 0, 0, 24, 15);
    end

    // randomized requests against the model
    for (int r = 0; r < 8; r++) begin
      int oka, fc;
      bit st;
      oka = $urandom_range(1, 5);
      st  = 1'($urandom_range(0, 1));
      fc  = st ? 2 : (oka < 2 ? 2 : oka);
      run(CW'($urandom), 4'($urandom), 9'($urandom), 1'($urandom), PALW'($urandom),
          oka, st, 1'($urandom_range(0, 1)), 4 * (4 + fc), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
